// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_pkg
//  Description : Shared core definitions for the instruction fetch path:
//                default datapath width, AXI response encoding and the
//                layout of one instruction-buffer entry.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

   // Default address / instruction width of the core.
   localparam int unsigned CORE_XLEN = 32;

   // AXI read response encoding; anything other than OKAY is an error.
   localparam logic [1:0] RESP_OKAY = 2'b00;

   // One buffered instruction. Field order fixes the packed layout that
   // the instruction buffer stores: {data, pc, fault}.
   typedef struct packed {
      logic [CORE_XLEN-1:0] data;
      logic [CORE_XLEN-1:0] pc;
      logic                 fault;
   } fetch_entry_t;

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Instruction buffer. Power-of-two deep FIFO with a
//                synchronous flush; push and pop in one cycle both apply.
//  Ports       : clk, rst (async, active-low)
//                push/din        - write one entry
//                pop             - consume head entry
//                flush           - discard all entries (wins over push/pop)
//                dout/valid      - head entry and non-empty flag
//                count           - number of stored entries
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 65
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned c_ptr_w = $clog2(DEPTH);
   localparam int unsigned c_cnt_w = c_ptr_w + 1;
   localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_cnt_w-1:0] r_count;

   logic w_do_push;
   logic w_do_pop;

   // A push into a full buffer is only legal when the head leaves in the
   // same cycle; the producer guarantees this never happens otherwise.
   assign w_do_pop  = pop && (r_count != '0);
   assign w_do_push = push && ((r_count != c_depth) || w_do_pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + c_cnt_w'(1);
            2'b01:   r_count <= r_count - c_cnt_w'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: nothing is visible until count says so.
   always_ff @(posedge clk) begin
      if (w_do_push && !flush) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   assign dout  = r_mem[r_rd_ptr];
   assign valid = (r_count != '0);
   assign count = r_count;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch front end. Issues sequential word reads
//                on an AXI read channel, buffers returned instructions and
//                hands them to decode. Supports single-cycle redirects that
//                flush the buffer and discard responses still in flight.
//  Ports       : clk, rst (async, active-low)
//                axi_imem_ar*    - read address channel (master)
//                axi_imem_r*     - read data channel (master)
//                redirect_valid/redirect_pc - branch/jump redirect
//                inst_valid/inst_ready/inst_data/inst_pc/inst_fault
//                                - decode-stage handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned      XLEN     = CORE_XLEN,
   parameter int unsigned      DEPTH    = 4,
   parameter int unsigned      MAX_OUT  = 2,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   output logic [XLEN-1:0]  axi_imem_araddr,
   output logic             axi_imem_arvalid,
   input  logic             axi_imem_arready,
   input  logic [XLEN-1:0]  axi_imem_rdata,
   input  logic [1:0]       axi_imem_rresp,
   input  logic             axi_imem_rvalid,
   output logic             axi_imem_rready,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_pc,
   output logic             inst_valid,
   input  logic             inst_ready,
   output logic [XLEN-1:0]  inst_data,
   output logic [XLEN-1:0]  inst_pc,
   output logic             inst_fault
);

   localparam int unsigned c_cnt_w   = $clog2(DEPTH) + 1;
   localparam int unsigned c_sum_w   = c_cnt_w + 1;
   localparam int unsigned c_entry_w = 2 * XLEN + 1;

   localparam logic [c_sum_w-1:0] c_max_out   = c_sum_w'(MAX_OUT);
   localparam logic [c_sum_w-1:0] c_depth     = c_sum_w'(DEPTH);
   localparam logic [XLEN-1:0]    c_word_step = XLEN'(4);
   localparam logic [XLEN-1:0]    c_word_mask = ~XLEN'(3);

   // Next address to request, address of the pending AR, and the PC that
   // belongs to the next response which will be kept.
   logic [XLEN-1:0]    r_pc;
   logic [XLEN-1:0]    r_araddr;
   logic               r_arvalid;
   logic [XLEN-1:0]    r_resp_pc;
   logic [c_cnt_w-1:0] r_acc_cnt;    // accepted, not yet answered
   logic [c_cnt_w-1:0] r_drop_cnt;   // responses still to be discarded

   logic               w_ar_hs;
   logic               w_r_hs;
   logic               w_rsp_cnt;
   logic               w_drop_rsp;
   logic               w_push;
   logic               w_pop;
   logic               w_fault;
   logic               w_raise;
   logic [XLEN-1:0]    w_redirect_pc;
   logic [XLEN-1:0]    w_pc_base;
   logic [c_cnt_w-1:0] w_acc_nxt;
   logic [c_sum_w-1:0] w_inflight_nxt;
   logic [c_sum_w-1:0] w_occ_nxt;

   logic [c_entry_w-1:0] w_fifo_din;
   logic [c_entry_w-1:0] w_fifo_dout;
   logic                 w_fifo_valid;
   logic [c_cnt_w-1:0]   w_fifo_count;
   logic [XLEN-1:0]      w_out_data;
   logic [XLEN-1:0]      w_out_pc;
   logic                 w_out_fault;

   // ------------------------------------------------------------------
   // Handshakes and response classification
   // ------------------------------------------------------------------
   assign axi_imem_rready = rst;

   assign w_ar_hs   = r_arvalid && axi_imem_arready;
   assign w_r_hs    = axi_imem_rvalid && axi_imem_rready;
   assign w_rsp_cnt = w_r_hs && (r_acc_cnt != '0);
   assign w_fault   = (axi_imem_rresp != RESP_OKAY);

   // A response in the redirect cycle belongs to the old path; it is
   // discarded here and therefore left out of the new drop count.
   assign w_drop_rsp = w_r_hs && (redirect_valid || (r_drop_cnt != '0));
   assign w_push     = w_r_hs && !w_drop_rsp;
   assign w_pop      = w_fifo_valid && inst_ready;

   assign w_redirect_pc = redirect_pc & c_word_mask;
   assign w_pc_base     = redirect_valid ? w_redirect_pc : r_pc;

   // ------------------------------------------------------------------
   // Request admission: look at next-cycle accepted count and buffer
   // occupancy so that every accepted request owns a buffer slot.
   // ------------------------------------------------------------------
   assign w_acc_nxt      = r_acc_cnt + c_cnt_w'(w_ar_hs) - c_cnt_w'(w_rsp_cnt);
   assign w_inflight_nxt = c_sum_w'(w_acc_nxt);
   assign w_occ_nxt      = redirect_valid ? '0
                         : c_sum_w'(w_fifo_count) + c_sum_w'(w_push) - c_sum_w'(w_pop);

   assign w_raise = (!r_arvalid || w_ar_hs)
                 && (w_inflight_nxt < c_max_out)
                 && ((w_inflight_nxt + w_occ_nxt) < c_depth);

   // ------------------------------------------------------------------
   // Fetch address, request and bookkeeping registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc       <= RESET_PC;
         r_araddr   <= '0;
         r_arvalid  <= 1'b0;
         r_resp_pc  <= RESET_PC;
         r_acc_cnt  <= '0;
         r_drop_cnt <= '0;
      end else begin
         // The fetch PC moves past an address as soon as that address is
         // committed to the AR channel; a pending AR is never rewritten,
         // so a redirect only affects the next request raised.
         if (w_raise) begin
            r_arvalid <= 1'b1;
            r_araddr  <= w_pc_base;
            r_pc      <= w_pc_base + c_word_step;
         end else begin
            if (w_ar_hs) begin
               r_arvalid <= 1'b0;
            end
            if (redirect_valid) begin
               r_pc <= w_redirect_pc;
            end
         end

         r_acc_cnt <= w_acc_nxt;

         // In flight = accepted-unanswered plus a pending AR, minus the
         // response being discarded this very cycle.
         if (redirect_valid) begin
            r_drop_cnt <= r_acc_cnt + c_cnt_w'(r_arvalid) - c_cnt_w'(w_rsp_cnt);
         end else if (w_r_hs && (r_drop_cnt != '0)) begin
            r_drop_cnt <= r_drop_cnt - c_cnt_w'(1);
         end

         if (redirect_valid) begin
            r_resp_pc <= w_redirect_pc;
         end else if (w_push) begin
            r_resp_pc <= r_resp_pc + c_word_step;
         end
      end
   end

   assign axi_imem_araddr  = r_araddr;
   assign axi_imem_arvalid = r_arvalid;

   // ------------------------------------------------------------------
   // Buffer entry packing
   // ------------------------------------------------------------------
   generate
      if (XLEN == CORE_XLEN) begin : g_entry_pkg
         fetch_entry_t w_entry_in;
         fetch_entry_t w_entry_out;

         assign w_entry_in.data  = axi_imem_rdata;
         assign w_entry_in.pc    = r_resp_pc;
         assign w_entry_in.fault = w_fault;
         assign w_fifo_din       = w_entry_in;

         assign w_entry_out = w_fifo_dout;
         assign w_out_data  = w_entry_out.data;
         assign w_out_pc    = w_entry_out.pc;
         assign w_out_fault = w_entry_out.fault;
      end else begin : g_entry_raw
         assign w_fifo_din = {axi_imem_rdata, r_resp_pc, w_fault};
         assign {w_out_data, w_out_pc, w_out_fault} = w_fifo_dout;
      end
   endgenerate

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (c_entry_w)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .pop   (w_pop),
      .flush (redirect_valid),
      .din   (w_fifo_din),
      .dout  (w_fifo_dout),
      .valid (w_fifo_valid),
      .count (w_fifo_count)
   );

   // Outputs read as zero whenever no instruction is presented.
   assign inst_valid = w_fifo_valid;
   assign inst_data  = w_fifo_valid ? w_out_data : '0;
   assign inst_pc    = w_fifo_valid ? w_out_pc   : '0;
   assign inst_fault = w_fifo_valid && w_out_fault;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit with a simple
//                one-cycle-latency instruction memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] axi_imem_araddr;
   logic        axi_imem_arvalid;
   logic        axi_imem_arready;
   logic [31:0] axi_imem_rdata;
   logic [1:0]  axi_imem_rresp;
   logic        axi_imem_rvalid;
   logic        axi_imem_rready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_fault;

   always #5 clk = ~clk;

   fetch_unit #(
      .XLEN     (32),
      .DEPTH    (4),
      .MAX_OUT  (2),
      .RESET_PC (32'h0)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .axi_imem_araddr  (axi_imem_araddr),
      .axi_imem_arvalid (axi_imem_arvalid),
      .axi_imem_arready (axi_imem_arready),
      .axi_imem_rdata   (axi_imem_rdata),
      .axi_imem_rresp   (axi_imem_rresp),
      .axi_imem_rvalid  (axi_imem_rvalid),
      .axi_imem_rready  (axi_imem_rready),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .inst_valid       (inst_valid),
      .inst_ready       (inst_ready),
      .inst_data        (inst_data),
      .inst_pc          (inst_pc),
      .inst_fault       (inst_fault)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
      logic        fault;
   } ev_t;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic        hold;
   logic [31:0] err_addr;
   ev_t         deliv[$];
   logic [31:0] acc_list[$];
   int          max_out;
   int          cur_out;
   logic        rsp_in_redirect;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h1357_0000;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [31:0] d_pc(input int i);
      return (i < deliv.size()) ? deliv[i].pc : 32'hDEAD_BEEF;
   endfunction
   function automatic logic [31:0] d_data(input int i);
      return (i < deliv.size()) ? deliv[i].data : 32'hDEAD_BEEF;
   endfunction
   function automatic logic d_fault(input int i);
      return (i < deliv.size()) ? deliv[i].fault : 1'bx;
   endfunction
   function automatic logic [31:0] a_addr(input int i);
      return (i < acc_list.size()) ? acc_list[i] : 32'hDEAD_BEEF;
   endfunction

   // Memory responder: answers each accepted AR one cycle later, in order.
   initial begin
      logic [31:0] mq[$];
      logic        do_ar;
      logic        do_r;
      logic [31:0] a;
      axi_imem_rvalid = 1'b0;
      axi_imem_rdata  = '0;
      axi_imem_rresp  = 2'b00;
      forever begin
         @(negedge clk);
         do_ar = rst && axi_imem_arvalid && axi_imem_arready;
         a     = axi_imem_araddr;
         do_r  = rst && axi_imem_rvalid && axi_imem_rready;
         @(posedge clk);
         #1;
         if (!rst) begin
            mq.delete();
            axi_imem_rvalid = 1'b0;
         end else begin
            if (do_r && mq.size() > 0) void'(mq.pop_front());
            if (do_ar) mq.push_back(a);
            if (!hold && mq.size() > 0) begin
               axi_imem_rvalid = 1'b1;
               axi_imem_rdata  = mem_word(mq[0]);
               axi_imem_rresp  = (mq[0] == err_addr) ? 2'b10 : 2'b00;
            end else begin
               axi_imem_rvalid = 1'b0;
               axi_imem_rresp  = 2'b00;
            end
         end
      end
   end

   // Monitor: records accepted addresses, delivered instructions and the
   // peak number of accepted-but-unanswered requests since reset.
   always @(negedge clk) begin
      if (!rst) begin
         cur_out         = 0;
         max_out         = 0;
         rsp_in_redirect = 1'b0;
      end else begin
         if (axi_imem_arvalid && axi_imem_arready) begin
            acc_list.push_back(axi_imem_araddr);
            cur_out++;
         end
         if (axi_imem_rvalid && axi_imem_rready) begin
            cur_out--;
            if (redirect_valid) rsp_in_redirect = 1'b1;
         end
         if (cur_out > max_out) max_out = cur_out;
         if (inst_valid && inst_ready) deliv.push_back('{inst_pc, inst_data, inst_fault});
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_reset();
      rst            = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      hold           = 1'b0;
      err_addr       = 32'hFFFF_FFFF;
      axi_imem_arready = 1'b1;
      inst_ready     = 1'b1;
      step(3);
   endtask

   task automatic pulse_redirect(input logic [31:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      step(1);
      redirect_valid = 1'b0;
   endtask

   initial begin
      int b;
      int ba;
      int bad;

      // ---- reset values and first request / latency --------------------
      do_reset();
      @(negedge clk);
      check("rst_arvalid", axi_imem_arvalid, 0);
      check("rst_rready", axi_imem_rready, 0);
      check("rst_inst_valid", inst_valid, 0);
      check("rst_inst_data", inst_data, 0);
      check("rst_inst_pc", inst_pc, 0);
      check("rst_inst_fault", inst_fault, 0);
      step(1);
      rst = 1'b1;
      b = deliv.size();
      @(negedge clk);
      check("pre_edge_arvalid", axi_imem_arvalid, 0);
      @(negedge clk);
      check("first_arvalid", axi_imem_arvalid, 1);
      check("first_araddr", axi_imem_araddr, 0);
      check("run_rready", axi_imem_rready, 1);
      @(negedge clk);
      check("lat_not_yet", inst_valid, 0);
      @(negedge clk);
      check("lat_valid", inst_valid, 1);
      check("lat_pc", inst_pc, 0);
      step(12);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("seq_pc%0d", i), d_pc(b + i), 32'(4 * i));
         check($sformatf("seq_data%0d", i), d_data(b + i), mem_word(32'(4 * i)));
      end

      // ---- back-pressure: buffer fills, request count bounded ----------
      do_reset();
      inst_ready = 1'b0;
      ba = acc_list.size();
      rst = 1'b1;
      step(20);
      @(negedge clk);
      check("bp_requests", acc_list.size() - ba, 4);
      check("bp_max_out_le2", (max_out <= 2), 1);
      check("bp_inst_valid", inst_valid, 1);
      check("bp_inst_pc_hold", inst_pc, 0);
      check("bp_inst_data_hold", inst_data, mem_word(32'h0));
      step(1);
      b = deliv.size();
      inst_ready = 1'b1;
      step(10);
      for (int i = 0; i < 5; i++)
         check($sformatf("bp_pc%0d", i), d_pc(b + i), 32'(4 * i));

      // ---- two outstanding, redirect to 0x103 --------------------------
      do_reset();
      hold = 1'b1;
      ba = acc_list.size();
      rst = 1'b1;
      step(6);
      @(negedge clk);
      check("ho_outstanding", max_out, 2);
      check("ho_requests", acc_list.size() - ba, 2);
      check("ho_arvalid_idle", axi_imem_arvalid, 0);
      step(1);
      hold = 1'b0;
      b = deliv.size();
      pulse_redirect(32'h103);
      step(12);
      check("rd1_pc0", d_pc(b), 32'h100);
      check("rd1_data0", d_data(b), mem_word(32'h100));
      check("rd1_pc1", d_pc(b + 1), 32'h104);

      // ---- pending AR held across redirect to 0x200 --------------------
      do_reset();
      axi_imem_arready = 1'b0;
      ba = acc_list.size();
      rst = 1'b1;
      step(3);
      b = deliv.size();
      pulse_redirect(32'h200);
      step(3);
      @(negedge clk);
      check("pend_arvalid", axi_imem_arvalid, 1);
      check("pend_araddr", axi_imem_araddr, 0);
      step(1);
      axi_imem_arready = 1'b1;
      step(12);
      check("pend_acc0", a_addr(ba), 32'h0);
      check("pend_acc1", a_addr(ba + 1), 32'h200);
      check("pend_deliv0", d_pc(b), 32'h200);

      // ---- error response on PC 0x8 ------------------------------------
      do_reset();
      err_addr = 32'h8;
      b = deliv.size();
      rst = 1'b1;
      step(12);
      check("err_pc", d_pc(b + 2), 32'h8);
      check("err_fault", d_fault(b + 2), 1);
      check("err_prev_ok", d_fault(b + 1), 0);
      check("err_next_pc", d_pc(b + 3), 32'hC);
      check("err_next_ok", d_fault(b + 3), 0);

      // ---- response and redirect in the same cycle ---------------------
      do_reset();
      hold = 1'b1;
      rst = 1'b1;
      step(6);
      hold = 1'b0;
      step(1);
      b = deliv.size();
      pulse_redirect(32'h300);
      step(12);
      check("same_rsp_seen", rsp_in_redirect, 1);
      check("same_pc0", d_pc(b), 32'h300);
      check("same_data0", d_data(b), mem_word(32'h300));
      bad = 0;
      for (int i = b; i < deliv.size(); i++)
         if (deliv[i].pc < 32'h300) bad++;
      check("same_no_stale", bad, 0);

      // ---- redirect with a full buffer and a pop in the same cycle -----
      do_reset();
      inst_ready = 1'b0;
      rst = 1'b1;
      step(10);
      inst_ready = 1'b1;
      pulse_redirect(32'h400);
      b = deliv.size();
      @(negedge clk);
      check("flush_inst_valid", inst_valid, 0);
      step(12);
      check("flush_pc0", d_pc(b), 32'h400);
      check("flush_pc1", d_pc(b + 1), 32'h404);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_fetch_unit
`default_nettype wire
